// File: rtl/mips32_pkg.sv
// Shared definitions for the MIPS32 issue-stage hazard scoreboard.
// Holds the opcode encodings used by the test programs, the architectural
// register address width and the scoreboard state encoding.
package mips32_pkg;

  localparam int REG_AW = 5;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_OR   = 6'b000011;
  localparam logic [5:0] OP_LW   = 6'b001000;
  localparam logic [5:0] OP_ADDI = 6'b001010;
  localparam logic [5:0] OP_HLT  = 6'b111111;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } sb_state_t;

endpackage

// File: rtl/mips32_sb_cell.sv
// One scoreboard entry: a countdown of cycles until the register's pending
// result becomes readable, plus a flag recording whether the producer was a
// load (its value only exists at write-back, so it cannot be bypassed early).
module mips32_sb_cell
  import mips32_pkg::*;
#(
  parameter int WB_LAT = 3,
  parameter int CW     = $clog2(WB_LAT + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          set_i,
  input  logic          is_load_i,
  output logic [CW-1:0] cnt_o,
  output logic          ld_o
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          ld_q,  ld_d;

  // A new producer reloads the full latency and wins over the decrement;
  // otherwise a nonzero count ticks down once per cycle.
  always_comb begin
    cnt_d = cnt_q;
    ld_d  = ld_q;
    if (set_i) begin
      cnt_d = CW'(WB_LAT);
      ld_d  = is_load_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Entry storage, cleared on reset so nothing is pending after start-up.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      ld_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ld_q  <= ld_d;
    end
  end

  assign cnt_o = cnt_q;
  assign ld_o  = ld_q;

endmodule

// File: rtl/mips32_hazard_scoreboard.sv
// Issue-stage interlock between ID and EX of the pipelined MIPS32 core.
// Tracks in-flight register writes with per-register countdowns, stalls an
// instruction whose sources are not yet readable, and sequences the HLT
// drain (RUN -> DRAIN -> HALTED).
// Optional build macro MIPS32_SB_FORWARD_EN: an EX/MEM bypass exists, so only
// a load result in its first cycle after issue blocks a consumer.
module mips32_hazard_scoreboard
  import mips32_pkg::*;
#(
  parameter int NREGS  = 32,
  parameter int WB_LAT = 3,
  parameter int SCW    = 16
) (
  input  logic                     clk1_i,
  input  logic                     rst_i,
  input  logic                     issue_valid_i,
  input  logic [$clog2(NREGS)-1:0] issue_rs_i,
  input  logic [$clog2(NREGS)-1:0] issue_rt_i,
  input  logic                     issue_uses_rs_i,
  input  logic                     issue_uses_rt_i,
  input  logic                     issue_wr_en_i,
  input  logic [$clog2(NREGS)-1:0] issue_rd_i,
  input  logic                     issue_is_load_i,
  input  logic                     issue_halt_i,
  input  logic                     flush_i,
  output logic                     stall_o,
  output logic                     issue_fire_o,
  output logic                     halted_o,
  output logic [NREGS-1:0]         pending_mask_o,
  output logic [SCW-1:0]           stall_cycles_o
);

  localparam int AW = $clog2(NREGS);
  localparam int CW = $clog2(WB_LAT + 1);

  logic [CW-1:0]    cnt [NREGS];
  logic [NREGS-1:0] ld_vec;
  logic             rs_busy;
  logic             rt_busy;
  sb_state_t        state_q, state_d;
  logic [SCW-1:0]   stall_cycles_q, stall_cycles_d;

  // R0 is hard-wired zero, so it never has a pending write.
  assign cnt[0]    = '0;
  assign ld_vec[0] = 1'b0;

  for (genvar r = 1; r < NREGS; r++) begin : g_cell
    logic set_r;
    assign set_r = issue_fire_o && issue_wr_en_i && (issue_rd_i == AW'(r));

    mips32_sb_cell #(
      .WB_LAT (WB_LAT),
      .CW     (CW)
    ) u_cell (
      .clk_i     (clk1_i),
      .rst_i     (rst_i),
      .set_i     (set_r),
      .is_load_i (issue_is_load_i),
      .cnt_o     (cnt[r]),
      .ld_o      (ld_vec[r])
    );
  end

  // A register is pending for as long as its countdown is running.
  always_comb begin
    pending_mask_o = '0;
    for (int r = 0; r < NREGS; r++) begin
      pending_mask_o[r] = (cnt[r] != '0);
    end
  end

`ifdef MIPS32_SB_FORWARD_EN
  // With the bypass only a load in its first in-flight cycle is unavailable;
  // ALU results reach the consumer without a bubble.
  assign rs_busy = (issue_rs_i != '0) && ld_vec[issue_rs_i] &&
                   (cnt[issue_rs_i] == CW'(WB_LAT));
  assign rt_busy = (issue_rt_i != '0) && ld_vec[issue_rt_i] &&
                   (cnt[issue_rt_i] == CW'(WB_LAT));
`else
  // Without a bypass any pending write blocks the reader until write-back.
  logic unused_ld;
  assign unused_ld = ^ld_vec;
  assign rs_busy   = (issue_rs_i != '0) && (cnt[issue_rs_i] != '0);
  assign rt_busy   = (issue_rt_i != '0) && (cnt[issue_rt_i] != '0);
`endif

  // Stall on a source hazard or whenever the pipe is draining/halted; a
  // flush only suppresses this cycle's fire and leaves older writes in flight.
  always_comb begin
    stall_o      = issue_valid_i && ((state_q != RUN) ||
                                     (issue_uses_rs_i && rs_busy) ||
                                     (issue_uses_rt_i && rt_busy));
    issue_fire_o = issue_valid_i && !stall_o && !flush_i;
  end

  // HLT sequencing: only a HLT that actually fires starts the drain, and the
  // core reports halted once every in-flight write has landed.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (issue_fire_o && issue_halt_i) state_d = DRAIN;
      DRAIN:   if (pending_mask_o == '0)         state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  // Saturating count of stalled cycles for performance statistics.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_o && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + SCW'(1);
    end
  end

  // State and statistics registers; reset from any state returns to RUN.
  always_ff @(posedge clk1_i) begin
    if (rst_i) begin
      state_q        <= RUN;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign halted_o       = (state_q == HALTED);
  assign stall_cycles_o = stall_cycles_q;

endmodule

// File: tb/tb_mips32_hazard_scoreboard.sv
// Directed testbench for mips32_hazard_scoreboard (NREGS=32, WB_LAT=3).
// Expectations follow the build: MIPS32_SB_FORWARD_EN selects bypass timing.
module tb_mips32_hazard_scoreboard;
  import mips32_pkg::*;

`ifdef MIPS32_SB_FORWARD_EN
  localparam int          RAW_STALLS = 0;
  localparam int          LU_STALLS  = 1;
  localparam logic [31:0] RAW_PEND   = 32'h0000_0012;
  localparam logic [31:0] LU_PEND    = 32'h0000_0012;
`else
  localparam int          RAW_STALLS = 3;
  localparam int          LU_STALLS  = 3;
  localparam logic [31:0] RAW_PEND   = 32'h0000_0010;
  localparam logic [31:0] LU_PEND    = 32'h0000_0010;
`endif

  logic              clk1 = 1'b0;
  logic              rst;
  logic              issueValid;
  logic [REG_AW-1:0] issueRs;
  logic [REG_AW-1:0] issueRt;
  logic              issueUsesRs;
  logic              issueUsesRt;
  logic              issueWrEn;
  logic [REG_AW-1:0] issueRd;
  logic              issueIsLoad;
  logic              issueHalt;
  logic              flush;
  logic              stall;
  logic              issueFire;
  logic              halted;
  logic [31:0]       pendingMask;
  logic [15:0]       stallCycles;

  int vectors     = 0;
  int miscompares = 0;

  mips32_hazard_scoreboard #(
    .NREGS  (32),
    .WB_LAT (3),
    .SCW    (16)
  ) dut (
    .clk1_i          (clk1),
    .rst_i           (rst),
    .issue_valid_i   (issueValid),
    .issue_rs_i      (issueRs),
    .issue_rt_i      (issueRt),
    .issue_uses_rs_i (issueUsesRs),
    .issue_uses_rt_i (issueUsesRt),
    .issue_wr_en_i   (issueWrEn),
    .issue_rd_i      (issueRd),
    .issue_is_load_i (issueIsLoad),
    .issue_halt_i    (issueHalt),
    .flush_i         (flush),
    .stall_o         (stall),
    .issue_fire_o    (issueFire),
    .halted_o        (halted),
    .pending_mask_o  (pendingMask),
    .stall_cycles_o  (stallCycles)
  );

  // Free-running clock; rising edge at 5, 15, 25, ...
  always #5 clk1 = ~clk1;

  // Watchdog so the run always ends even if something locks up.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic setIdle();
    issueValid  = 1'b0;
    issueRs     = '0;
    issueRt     = '0;
    issueUsesRs = 1'b0;
    issueUsesRt = 1'b0;
    issueWrEn   = 1'b0;
    issueRd     = '0;
    issueIsLoad = 1'b0;
    issueHalt   = 1'b0;
    flush       = 1'b0;
  endtask

  // Present one decoded instruction in ID.
  task automatic applyStimulus(input logic urs, input logic [REG_AW-1:0] rs,
                               input logic urt, input logic [REG_AW-1:0] rt,
                               input logic wr, input logic [REG_AW-1:0] rd,
                               input logic ld, input logic hlt);
    issueValid  = 1'b1;
    issueUsesRs = urs;
    issueRs     = rs;
    issueUsesRt = urt;
    issueRt     = rt;
    issueWrEn   = wr;
    issueRd     = rd;
    issueIsLoad = ld;
    issueHalt   = hlt;
    flush       = 1'b0;
  endtask

  // Hold reset over two rising edges and release it at a falling edge.
  task automatic doReset();
    rst = 1'b1;
    setIdle();
    @(negedge clk1);
    @(negedge clk1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    #1;
    vectors++;
    if (stall !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_stall: got %b expected 0", stall);
    end
    vectors++;
    if (issueFire !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_fire: got %b expected 0", issueFire);
    end
    vectors++;
    if (halted !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_halted: got %b expected 0", halted);
    end
    vectors++;
    if (pendingMask !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_pending: got %h expected 0", pendingMask);
    end
    vectors++;
    if (stallCycles !== 16'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_stall_cycles: got %0d expected 0", stallCycles);
    end
  endtask

  // ADDI R1,R0,10 followed by ADD R4,R1,R2 held in ID.
  task automatic test_raw_stall();
    doReset();
    applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 5'd1, 1'b0, 1'b0);
    #1;
    vectors++;
    if (issueFire !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL raw_addi_fire: got %b expected 1", issueFire);
    end
    @(negedge clk1);
    applyStimulus(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd4, 1'b0, 1'b0);
    for (int i = 0; i < RAW_STALLS; i++) begin
      #1;
      vectors++;
      if (stall !== 1'b1 || issueFire !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL raw_bubble%0d: got stall=%b fire=%b expected stall=1 fire=0",
                 i, stall, issueFire);
      end
      @(negedge clk1);
    end
    #1;
    vectors++;
    if (stall !== 1'b0 || issueFire !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL raw_add_fire: got stall=%b fire=%b expected stall=0 fire=1",
               stall, issueFire);
    end
    @(negedge clk1);
    setIdle();
    #1;
    vectors++;
    if (stallCycles !== 16'(RAW_STALLS)) begin
      miscompares++;
      $display("[TB] FAIL raw_stall_cycles: got %0d expected %0d", stallCycles, RAW_STALLS);
    end
    vectors++;
    if (pendingMask !== RAW_PEND) begin
      miscompares++;
      $display("[TB] FAIL raw_pending: got %h expected %h", pendingMask, RAW_PEND);
    end
  endtask

  // LW R1 followed by ADD R4,R1,R2.
  task automatic test_load_use();
    doReset();
    applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 5'd1, 1'b1, 1'b0);
    #1;
    vectors++;
    if (issueFire !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL lu_lw_fire: got %b expected 1", issueFire);
    end
    @(negedge clk1);
    applyStimulus(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd4, 1'b0, 1'b0);
    for (int i = 0; i < LU_STALLS; i++) begin
      #1;
      vectors++;
      if (stall !== 1'b1 || issueFire !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL lu_bubble%0d: got stall=%b fire=%b expected stall=1 fire=0",
                 i, stall, issueFire);
      end
      @(negedge clk1);
    end
    #1;
    vectors++;
    if (stall !== 1'b0 || issueFire !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL lu_add_fire: got stall=%b fire=%b expected stall=0 fire=1",
               stall, issueFire);
    end
    @(negedge clk1);
    setIdle();
    #1;
    vectors++;
    if (stallCycles !== 16'(LU_STALLS)) begin
      miscompares++;
      $display("[TB] FAIL lu_stall_cycles: got %0d expected %0d", stallCycles, LU_STALLS);
    end
    vectors++;
    if (pendingMask !== LU_PEND) begin
      miscompares++;
      $display("[TB] FAIL lu_pending: got %h expected %h", pendingMask, LU_PEND);
    end
  endtask

  // ADDI R0,R0,5 then ADD R3,R0,R0: R0 is never pending.
  task automatic test_r0();
    doReset();
    applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
    #1;
    vectors++;
    if (issueFire !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL r0_addi_fire: got %b expected 1", issueFire);
    end
    @(negedge clk1);
    applyStimulus(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd3, 1'b0, 1'b0);
    #1;
    vectors++;
    if (pendingMask !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL r0_pending: got %h expected 0", pendingMask);
    end
    vectors++;
    if (stall !== 1'b0 || issueFire !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL r0_add_fire: got stall=%b fire=%b expected stall=0 fire=1",
               stall, issueFire);
    end
    @(negedge clk1);
    setIdle();
    #1;
    vectors++;
    if (pendingMask !== 32'h0000_0008) begin
      miscompares++;
      $display("[TB] FAIL r0_pending_r3: got %h expected 00000008", pendingMask);
    end
  endtask

  // ADDI R2,R0,20 then HLT: drain, halt, stall while halted, reset recovers.
  task automatic test_halt();
    doReset();
    applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 5'd2, 1'b0, 1'b0);
    @(negedge clk1);
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    #1;
    vectors++;
    if (issueFire !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL hlt_fire: got %b expected 1", issueFire);
    end
    @(negedge clk1);
    setIdle();
    #1;
    vectors++;
    if (pendingMask !== 32'h4 || halted !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL hlt_drain1: got pend=%h halted=%b expected pend=00000004 halted=0",
               pendingMask, halted);
    end
    @(negedge clk1);
    applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0);
    #1;
    vectors++;
    if (pendingMask !== 32'h4 || halted !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL hlt_drain2: got pend=%h halted=%b expected pend=00000004 halted=0",
               pendingMask, halted);
    end
    vectors++;
    if (stall !== 1'b1 || issueFire !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL hlt_drain_stall: got stall=%b fire=%b expected stall=1 fire=0",
               stall, issueFire);
    end
    @(negedge clk1);
    setIdle();
    #1;
    vectors++;
    if (pendingMask !== 32'h0 || halted !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL hlt_drain3: got pend=%h halted=%b expected pend=0 halted=0",
               pendingMask, halted);
    end
    @(negedge clk1);
    applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0);
    #1;
    vectors++;
    if (halted !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL hlt_halted: got %b expected 1", halted);
    end
    vectors++;
    if (stall !== 1'b1 || issueFire !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL hlt_halted_stall: got stall=%b fire=%b expected stall=1 fire=0",
               stall, issueFire);
    end
    @(negedge clk1);
    #1;
    vectors++;
    if (halted !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL hlt_stays_halted: got %b expected 1", halted);
    end
    doReset();
    applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0);
    #1;
    vectors++;
    if (halted !== 1'b0 || stall !== 1'b0 || issueFire !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL hlt_reset_run: got halted=%b stall=%b fire=%b expected 0 0 1",
               halted, stall, issueFire);
    end
  endtask

  // A flushed HLT neither fires nor starts the drain; counters keep running.
  task automatic test_flush();
    doReset();
    applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 5'd1, 1'b0, 1'b0);
    @(negedge clk1);
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    flush = 1'b1;
    #1;
    vectors++;
    if (issueFire !== 1'b0 || stall !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL flush_hlt: got fire=%b stall=%b expected fire=0 stall=0",
               issueFire, stall);
    end
    @(negedge clk1);
    setIdle();
    #1;
    vectors++;
    if (pendingMask !== 32'h2 || halted !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL flush_pending: got pend=%h halted=%b expected pend=00000002 halted=0",
               pendingMask, halted);
    end
    @(negedge clk1);
    applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 5'd6, 1'b0, 1'b0);
    #1;
    vectors++;
    if (stall !== 1'b0 || issueFire !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL flush_still_run: got stall=%b fire=%b expected stall=0 fire=1",
               stall, issueFire);
    end
    vectors++;
    if (pendingMask !== 32'h2) begin
      miscompares++;
      $display("[TB] FAIL flush_countdown: got %h expected 00000002", pendingMask);
    end
    @(negedge clk1);
    setIdle();
  endtask

  initial begin
    rst = 1'b1;
    setIdle();
    test_reset();
    test_raw_stall();
    test_load_use();
    test_r0();
    test_halt();
    test_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
